// File: rtl/arbitro_mux_vagas_if.sv
// Bus between the vacancy-count requesters, the shared 4x1 mux select and the
// occupancy register capture strobe.
interface arbitro_mux_vagas_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       cap;
    logic       busy;

    modport master (
        input  req,
        output gnt, s0, s1, cap, busy
    );

    modport slave (
        output req,
        input  gnt, s0, s1, cap, busy
    );
endinterface

// File: rtl/arbitro_mux_vagas.sv
// Round-robin arbiter for the shared vacancy mux: one-hot grant, mux select and
// a one-cycle capture strobe in the gap after every grant.
module arbitro_mux_vagas #(
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arbitro_mux_vagas_if.master  bus
);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       sel, sel_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       gnt, gnt_nxt;
    logic             cap, cap_nxt;
    logic             busy, busy_nxt;
    logic             arb_found;
    logic [1:0]       arb_win;

    // Search ptr, ptr+1, ... wrapping mod 4; the first active request wins.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] win;
        logic [1:0] cand;
        found = 1'b0;
        win   = p;
        for (int i = 0; i < 4; i++) begin
            cand = p + i[1:0];
            if (!found && r[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        return {found, win};
    endfunction

    assign {arb_found, arb_win} = pick(bus.req, ptr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            cnt   <= '0;
            gnt   <= 4'd0;
            cap   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            cap   <= cap_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        cap_nxt   = 1'b0;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                gnt_nxt  = 4'd0;
                busy_nxt = 1'b0;
                if (arb_found) begin
                    state_nxt = GRANT;
                    sel_nxt   = arb_win;
                    gnt_nxt   = 4'b0001 << arb_win;
                    cnt_nxt   = CNT_W'(1);
                    busy_nxt  = 1'b1;
                end
            end
            GRANT: begin
                // A drop and an expired hold on the same edge give a single exit.
                if (!bus.req[sel] || cnt == HOLD_LIM) begin
                    state_nxt = GAP;
                    gnt_nxt   = 4'd0;
                    cap_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    ptr_nxt   = sel + 2'd1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (arb_found) begin
                    state_nxt = GRANT;
                    sel_nxt   = arb_win;
                    gnt_nxt   = 4'b0001 << arb_win;
                    cnt_nxt   = CNT_W'(1);
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'd0;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'd0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.gnt  = gnt;
    assign bus.s1   = sel[1];
    assign bus.s0   = sel[0];
    assign bus.cap  = cap;
    assign bus.busy = busy;
endmodule

// File: tb/tb_arbitro_mux_vagas.sv
// Directed bench for arbitro_mux_vagas: three instances (HOLD_MAX 8, 2, 4)
// share clock and reset; each scenario drives one of them.
module tb_arbitro_mux_vagas;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    arbitro_mux_vagas_if if8 ();
    arbitro_mux_vagas_if if2 ();
    arbitro_mux_vagas_if if4 ();

    arbitro_mux_vagas #(.HOLD_MAX(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    arbitro_mux_vagas #(.HOLD_MAX(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    arbitro_mux_vagas #(.HOLD_MAX(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    // Observed outputs packed as {gnt, s1, s0, cap, busy}
    logic [7:0] obs8, obs2, obs4;
    assign obs8 = {if8.gnt, if8.s1, if8.s0, if8.cap, if8.busy};
    assign obs2 = {if2.gnt, if2.s1, if2.s0, if2.cap, if2.busy};
    assign obs4 = {if4.gnt, if4.s1, if4.s0, if4.cap, if4.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] expv(input logic [3:0] g, input logic [1:0] sel,
                                        input logic c, input logic b);
        return {g, sel, c, b};
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] w);
        return 4'b0001 << w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed gnt/sel/cap/busy=%b_%b_%b_%b expected=%b_%b_%b_%b",
                   tag, obs[7:4], obs[3:2], obs[1], obs[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [1:0] rr_order [5];
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        if8.req = 4'b1111;
        if2.req = 4'b0000;
        if4.req = 4'b0000;

        // Reset with all requests high: everything stays at zero
        tick();
        check_output("reset_c1", obs8, expv(4'b0000, 2'b00, 1'b0, 1'b0));
        tick();
        check_output("reset_c2", obs8, expv(4'b0000, 2'b00, 1'b0, 1'b0));
        check_output("reset_u2", obs2, expv(4'b0000, 2'b00, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        check_output("first_grant", obs8, expv(4'b0001, 2'b00, 1'b0, 1'b1));
        if8.req = 4'b0000;
        tick();
        check_output("first_gap", obs8, expv(4'b0000, 2'b00, 1'b1, 1'b1));
        tick();
        check_output("first_idle", obs8, expv(4'b0000, 2'b00, 1'b0, 1'b0));

        // Single request held three cycles, HOLD_MAX=8
        if8.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("single_grant%0d", i), obs8, expv(4'b0100, 2'b10, 1'b0, 1'b1));
        end
        if8.req = 4'b0000;
        tick();
        check_output("single_cap", obs8, expv(4'b0000, 2'b10, 1'b1, 1'b1));
        tick();
        check_output("single_idle", obs8, expv(4'b0000, 2'b10, 1'b0, 1'b0));
        tick();
        check_output("single_idle_hold", obs8, expv(4'b0000, 2'b10, 1'b0, 1'b0));

        // Round robin with all requesting, HOLD_MAX=2
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        if2.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 2; c++) begin
                tick();
                check_output($sformatf("rr%0d_grant%0d", k, c), obs2,
                             expv(onehot(rr_order[k]), rr_order[k], 1'b0, 1'b1));
            end
            tick();
            check_output($sformatf("rr%0d_gap", k), obs2, expv(4'b0000, rr_order[k], 1'b1, 1'b1));
        end
        if2.req = 4'b0000;
        tick();
        check_output("rr_idle", obs2, expv(4'b0000, 2'b00, 1'b0, 1'b0));

        // Sole requester forced rotation, HOLD_MAX=4
        if4.req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ((i % 5) < 4)
                check_output($sformatf("sole_grant%0d", i), obs4, expv(4'b0010, 2'b01, 1'b0, 1'b1));
            else
                check_output($sformatf("sole_gap%0d", i), obs4, expv(4'b0000, 2'b01, 1'b1, 1'b1));
        end
        if4.req = 4'b0000;
        tick();
        check_output("sole_idle", obs4, expv(4'b0000, 2'b01, 1'b0, 1'b0));

        // Pointer fairness: after requester 3 the pointer wraps to 0
        if8.req = 4'b1000;
        tick();
        check_output("fair_grant3", obs8, expv(4'b1000, 2'b11, 1'b0, 1'b1));
        if8.req = 4'b0000;
        tick();
        check_output("fair_gap3", obs8, expv(4'b0000, 2'b11, 1'b1, 1'b1));
        tick();
        check_output("fair_idle", obs8, expv(4'b0000, 2'b11, 1'b0, 1'b0));
        if8.req = 4'b1001;
        tick();
        check_output("fair_grant0", obs8, expv(4'b0001, 2'b00, 1'b0, 1'b1));
        if8.req = 4'b1000;
        tick();
        check_output("fair_gap0", obs8, expv(4'b0000, 2'b00, 1'b1, 1'b1));
        tick();
        check_output("fair_regrant3", obs8, expv(4'b1000, 2'b11, 1'b0, 1'b1));
        if8.req = 4'b0000;
        tick();
        check_output("fair_gap_end", obs8, expv(4'b0000, 2'b11, 1'b1, 1'b1));
        tick();
        check_output("fair_idle_end", obs8, expv(4'b0000, 2'b11, 1'b0, 1'b0));

        // Reset in the second cycle of a grant to requester 2 (pointer is 1 then)
        if8.req = 4'b0001;
        tick();
        check_output("mid_pre_grant0", obs8, expv(4'b0001, 2'b00, 1'b0, 1'b1));
        if8.req = 4'b0100;
        tick();
        check_output("mid_pre_gap", obs8, expv(4'b0000, 2'b00, 1'b1, 1'b1));
        tick();
        check_output("mid_grant2_c1", obs8, expv(4'b0100, 2'b10, 1'b0, 1'b1));
        tick();
        check_output("mid_grant2_c2", obs8, expv(4'b0100, 2'b10, 1'b0, 1'b1));
        rst_n = 1'b0;
        tick();
        check_output("mid_reset_c1", obs8, expv(4'b0000, 2'b00, 1'b0, 1'b0));
        tick();
        check_output("mid_reset_c2", obs8, expv(4'b0000, 2'b00, 1'b0, 1'b0));
        rst_n   = 1'b1;
        if8.req = 4'b0011;
        tick();
        check_output("mid_ptr_cleared", obs8, expv(4'b0001, 2'b00, 1'b0, 1'b1));
        if8.req = 4'b0000;
        tick();
        check_output("mid_final_gap", obs8, expv(4'b0000, 2'b00, 1'b1, 1'b1));
        tick();
        check_output("mid_final_idle", obs8, expv(4'b0000, 2'b00, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
